// File: rtl/ap_ctrl_hs_driver.sv
// ---------------------------------------------------------------------------
// ap_ctrl_hs_driver
//
// Initiator for the ap_ctrl_hs block-level handshake. A host command asks
// for cmd_count kernel transactions. The driver raises ap_start and keeps up
// to DEPTH transactions in flight. These are accepted by the kernel but not
// yet done. Each completion updates latency statistics. Latency is the number
// of cycles from the first cycle ap_start is high for a transaction to the
// cycle ap_done retires it.
//
// Parameters
//   DEPTH  max outstanding transactions (power of two, 1..16)
//   CNT_W  width of the free-running cycle stamp and of latency values
//   TXN_W  width of transaction counts
//
// Ports
//   clock, reset     single rising-edge clock; synchronous active-high reset
//   cmd_valid/ready  command handshake; ready is high only while IDLE
//   cmd_count        number of transactions, sampled at command accept
//   ap_start         registered kernel start
//   ap_ready         kernel accepted the current start
//   ap_done          kernel finished the oldest outstanding transaction
//   busy             high while a command is running
//   done_cnt         completions in the current command
//   lat_last/min/max latency of the last completion / minimum / maximum
//   lat_sum          running sum of latencies
//   finish           one-cycle pulse when the command completes
//   err_done         sticky: ap_done arrived with nothing outstanding
// ---------------------------------------------------------------------------
module ap_ctrl_hs_driver #(
  parameter int DEPTH = 4,
  parameter int CNT_W = 32,
  parameter int TXN_W = 16
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic                   cmd_valid,
  output logic                   cmd_ready,
  input  logic [TXN_W-1:0]       cmd_count,
  output logic                   ap_start,
  input  logic                   ap_ready,
  input  logic                   ap_done,
  output logic                   busy,
  output logic [TXN_W-1:0]       done_cnt,
  output logic [CNT_W-1:0]       lat_last,
  output logic [CNT_W-1:0]       lat_min,
  output logic [CNT_W-1:0]       lat_max,
  output logic [CNT_W+TXN_W-1:0] lat_sum,
  output logic                   finish,
  output logic                   err_done
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int OCC_W = $clog2(DEPTH + 1);
  localparam int SUM_W = CNT_W + TXN_W;
  localparam logic [PTR_W-1:0] PTR_LAST = PTR_W'(DEPTH - 1);
  localparam logic [OCC_W-1:0] OCC_FULL = OCC_W'(DEPTH);

  typedef enum logic {IDLE, RUN} state_t;

  state_t           state;
  logic [TXN_W-1:0] cmd_len;     // latched cmd_count
  logic [TXN_W-1:0] issued;      // transactions accepted by the kernel
  logic [OCC_W-1:0] occ;         // accepted but not yet done
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [CNT_W-1:0] cyc;         // free-running cycle stamp, wraps
  logic [CNT_W-1:0] issue_ts;    // cyc at the first start cycle of the pending txn
  logic [CNT_W-1:0] ts_mem [DEPTH];

  logic             accept;
  logic             fifo_empty;
  logic             bypass;
  logic             push;
  logic             pop;
  logic             completion;
  logic             unexpected;
  logic             start_next;
  logic [CNT_W-1:0] head_ts;
  logic [CNT_W-1:0] lat;
  logic [TXN_W-1:0] issued_next;
  logic [TXN_W-1:0] done_next;
  logic [OCC_W-1:0] occ_next;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_LAST) ? '0 : p + PTR_W'(1);
  endfunction

  assign cmd_ready = (state == IDLE);
  assign busy      = (state == RUN);

  // NOTE: every signal here is assigned on every path through the block, so
  // no storage (latch) can be inferred.
  always_comb begin
    accept     = ap_start && ap_ready;
    fifo_empty = (occ == '0);
    // A done that lands on the accept cycle of the only transaction retires
    // it directly; its stamp never enters the FIFO.
    bypass     = accept && ap_done && fifo_empty;
    push       = accept && !bypass;
    pop        = ap_done && !fifo_empty;
    completion = bypass || pop;
    unexpected = ap_done && fifo_empty && !accept;

    head_ts    = bypass ? issue_ts : ts_mem[rd_ptr];
    // Modular subtraction gives the right latency across a wrap of cyc.
    lat        = cyc - head_ts;

    issued_next = issued + TXN_W'(accept);
    done_next   = done_cnt + TXN_W'(completion);
    occ_next    = occ + OCC_W'(push) - OCC_W'(pop);

    // While ap_start is high and unaccepted, issued_next and occ_next cannot
    // rise, so this never drops a start the kernel has not taken.
    start_next  = (issued_next < cmd_len) && (occ_next < OCC_FULL);
  end

  // NOTE: the timestamp store has no reset. Only occupancy and the pointers
  // decide which entries are live, so stale data is never read.
  always_ff @(posedge clock) begin
    if (push) ts_mem[wr_ptr] <= issue_ts;
  end

  // NOTE: all state is updated with non-blocking assignments. Every branch
  // therefore sees pre-edge values, and the *_next terms above carry the
  // look-ahead instead of chained blocking updates.
  always_ff @(posedge clock) begin
    if (reset) begin
      state    <= IDLE;
      cmd_len  <= '0;
      issued   <= '0;
      occ      <= '0;
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      cyc      <= '0;
      issue_ts <= '0;
      ap_start <= 1'b0;
      done_cnt <= '0;
      lat_last <= '0;
      lat_min  <= '1;
      lat_max  <= '0;
      lat_sum  <= '0;
      finish   <= 1'b0;
      err_done <= 1'b0;
    end else begin
      cyc    <= cyc + CNT_W'(1);
      finish <= 1'b0;

      case (state)
        IDLE: begin
          if (unexpected) err_done <= 1'b1;
          if (cmd_valid) begin
            cmd_len  <= cmd_count;
            issued   <= '0;
            done_cnt <= '0;
            lat_last <= '0;
            lat_min  <= '1;
            lat_max  <= '0;
            lat_sum  <= '0;
            err_done <= 1'b0;
            if (cmd_count == '0) begin
              // Empty command: report completion without touching the kernel.
              finish <= 1'b1;
            end else begin
              state    <= RUN;
              ap_start <= 1'b1;
              issue_ts <= cyc + CNT_W'(1);
            end
          end
        end

        RUN: begin
          issued <= issued_next;
          occ    <= occ_next;
          if (push) wr_ptr <= ptr_inc(wr_ptr);
          if (pop)  rd_ptr <= ptr_inc(rd_ptr);

          ap_start <= start_next;
          // A fresh transaction begins either after a low gap or immediately
          // after an accept. Stamp it with the cycle it first appears.
          if (start_next && (!ap_start || accept)) issue_ts <= cyc + CNT_W'(1);

          if (unexpected) err_done <= 1'b1;

          if (completion) begin
            done_cnt <= done_next;
            lat_last <= lat;
            lat_min  <= (lat < lat_min) ? lat : lat_min;
            lat_max  <= (lat > lat_max) ? lat : lat_max;
            lat_sum  <= lat_sum + SUM_W'(lat);
            if (done_next == cmd_len) begin
              state  <= IDLE;
              finish <= 1'b1;
            end
          end
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_ap_ctrl_hs_driver.sv
// ---------------------------------------------------------------------------
// tb_ap_ctrl_hs_driver
//
// Directed bench for ap_ctrl_hs_driver built with CNT_W=8, so the cycle
// stamp wraps every 256 cycles. A small kernel responder derives ap_ready
// and ap_done from the observed ap_start. Expected values are hand-computed
// from the kernel timing chosen for each step.
// ---------------------------------------------------------------------------
module tb_ap_ctrl_hs_driver;

  localparam int DEPTH = 4;
  localparam int CNT_W = 8;
  localparam int TXN_W = 16;
  localparam logic [CNT_W-1:0] ALL_ONES = '1;

  typedef struct {
    int start_t;
    int done_t;
  } txn_t;

  logic                   clock = 1'b0;
  logic                   reset;
  logic                   cmd_valid;
  logic                   cmd_ready;
  logic [TXN_W-1:0]       cmd_count;
  logic                   ap_start;
  logic                   ap_ready;
  logic                   ap_done;
  logic                   busy;
  logic [TXN_W-1:0]       done_cnt;
  logic [CNT_W-1:0]       lat_last;
  logic [CNT_W-1:0]       lat_min;
  logic [CNT_W-1:0]       lat_max;
  logic [CNT_W+TXN_W-1:0] lat_sum;
  logic                   finish;
  logic                   err_done;

  int n_tests = 0;
  int n_fail  = 0;
  int max_occ = 0;

  ap_ctrl_hs_driver #(.DEPTH(DEPTH), .CNT_W(CNT_W), .TXN_W(TXN_W)) dut (
    .clock     (clock),
    .reset     (reset),
    .cmd_valid (cmd_valid),
    .cmd_ready (cmd_ready),
    .cmd_count (cmd_count),
    .ap_start  (ap_start),
    .ap_ready  (ap_ready),
    .ap_done   (ap_done),
    .busy      (busy),
    .done_cnt  (done_cnt),
    .lat_last  (lat_last),
    .lat_min   (lat_min),
    .lat_max   (lat_max),
    .lat_sum   (lat_sum),
    .finish    (finish),
    .err_done  (err_done)
  );

  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Outputs are sampled 1 time unit after the rising edge; inputs written
  // here are taken at the following edge.
  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic send_cmd(input string name, input int n);
    cmd_valid = 1'b1;
    cmd_count = TXN_W'(n);
    check({name, "_cmd_ready_before"}, cmd_ready, 1);
    tick();
    cmd_valid = 1'b0;
    check({name, "_err_cleared"}, err_done, 0);
    check({name, "_done_cnt_cleared"}, done_cnt, 0);
    if (n > 0) begin
      check({name, "_start_at_T1"}, ap_start, 1);
      check({name, "_busy"}, busy, 1);
      check({name, "_cmd_ready_low"}, cmd_ready, 0);
    end
  endtask

  // Kernel responder: ap_ready comes ready_delay cycles after a start first
  // appears. ap_done comes done_after cycles after the accept, retiring in
  // order. Runs until finish is seen or the budget is exhausted.
  task automatic run_kernel(input string name, input int ready_delay, input int done_after,
                            input int exp_lat, input int budget);
    txn_t q[$];
    txn_t nt;
    txn_t head;
    int   t          = 0;
    int   start_t    = 0;
    int   n_done     = 0;
    bit   in_start   = 1'b0;
    bit   pend       = 1'b0;
    bit   got_finish = 1'b0;
    max_occ = 0;
    while (!got_finish && t < budget) begin
      if (pend) begin
        check({name, "_lat_last"}, lat_last, exp_lat);
        check({name, "_done_cnt"}, done_cnt, n_done);
        pend = 1'b0;
      end
      if (finish) begin
        got_finish = 1'b1;
        check({name, "_finish_start_low"}, ap_start, 0);
        check({name, "_finish_busy_low"}, busy, 0);
        check({name, "_finish_cmd_ready"}, cmd_ready, 1);
      end else begin
        if (q.size() == DEPTH) check({name, "_start_low_full"}, ap_start, 0);
        if (in_start) check({name, "_start_held"}, ap_start, 1);
        else if (ap_start) begin
          in_start = 1'b1;
          start_t  = t;
        end
        ap_ready = in_start && ((t - start_t) >= ready_delay);
        ap_done  = 1'b0;
        if (ap_ready) begin
          nt.start_t = start_t;
          nt.done_t  = t + done_after;
          q.push_back(nt);
          in_start = 1'b0;
        end
        if (q.size() > 0 && q[0].done_t == t) begin
          head    = q.pop_front();
          ap_done = 1'b1;
          n_done++;
          pend    = 1'b1;
        end
        if (q.size() > max_occ) max_occ = q.size();
        tick();
        t++;
      end
    end
    ap_ready = 1'b0;
    ap_done  = 1'b0;
    if (!got_finish) check({name, "_timeout_finish"}, finish, 1);
  endtask

  initial begin
    reset     = 1'b1;
    cmd_valid = 1'b0;
    cmd_count = '0;
    ap_ready  = 1'b0;
    ap_done   = 1'b0;
    tick();
    tick();
    reset = 1'b0;

    // Reset values
    check("rst_cmd_ready", cmd_ready, 1);
    check("rst_ap_start", ap_start, 0);
    check("rst_busy", busy, 0);
    check("rst_done_cnt", done_cnt, 0);
    check("rst_lat_last", lat_last, 0);
    check("rst_lat_min", lat_min, ALL_ONES);
    check("rst_lat_max", lat_max, 0);
    check("rst_lat_sum", lat_sum, 0);
    check("rst_finish", finish, 0);
    check("rst_err_done", err_done, 0);

    // Unexpected done in IDLE: sticky error, statistics untouched
    ap_done = 1'b1;
    tick();
    ap_done = 1'b0;
    check("unexp_err_set", err_done, 1);
    check("unexp_done_cnt", done_cnt, 0);
    check("unexp_lat_min", lat_min, ALL_ONES);
    check("unexp_lat_max", lat_max, 0);
    check("unexp_lat_sum", lat_sum, 0);
    tick();
    tick();
    check("unexp_err_sticky", err_done, 1);

    // Non-pipelined kernel: ready+done together 10 cycles after each start.
    // send_cmd also confirms that the accept clears err_done.
    send_cmd("np", 3);
    run_kernel("np", 10, 0, 10, 200);
    check("np_done_cnt_final", done_cnt, 3);
    check("np_lat_min", lat_min, 10);
    check("np_lat_max", lat_max, 10);
    check("np_lat_sum", lat_sum, 30);
    check("np_err_done", err_done, 0);
    tick();
    check("np_finish_once", finish, 0);

    // Zero-count command
    send_cmd("zero", 0);
    check("zero_finish_T1", finish, 1);
    check("zero_ap_start", ap_start, 0);
    check("zero_busy", busy, 0);
    check("zero_cmd_ready", cmd_ready, 1);
    check("zero_lat_min", lat_min, ALL_ONES);
    check("zero_lat_sum", lat_sum, 0);
    for (int i = 0; i < 4; i++) begin
      tick();
      check("zero_no_start", ap_start, 0);
      check("zero_finish_pulse", finish, 0);
    end

    // Pipelined kernel: ready one cycle after start, done 20 after start
    send_cmd("pipe", 8);
    run_kernel("pipe", 1, 19, 20, 400);
    check("pipe_max_occ", max_occ, DEPTH);
    check("pipe_done_cnt_final", done_cnt, 8);
    check("pipe_lat_min", lat_min, 20);
    check("pipe_lat_max", lat_max, 20);
    check("pipe_lat_sum", lat_sum, 160);
    check("pipe_err_done", err_done, 0);

    // Wrap and stall: reset zeroes cyc, idle to cyc=245. The start stamp is
    // then 246, ready is held low 5 cycles, and done comes 12 cycles after
    // the accept at cyc 263 mod 256 = 7, which gives a latency of 17.
    reset = 1'b1;
    tick();
    reset = 1'b0;
    for (int i = 0; i < 245; i++) tick();
    send_cmd("wrap", 1);
    run_kernel("wrap", 5, 12, 17, 100);
    check("wrap_lat_min", lat_min, 17);
    check("wrap_lat_max", lat_max, 17);
    check("wrap_lat_sum", lat_sum, 17);

    // Reset with three transactions outstanding
    tick();
    send_cmd("mid", 8);
    ap_ready = 1'b1;
    tick();
    tick();
    tick();
    check("mid_start_still_high", ap_start, 1);
    reset    = 1'b1;
    ap_ready = 1'b0;
    tick();
    reset = 1'b0;
    check("mid_rst_ap_start", ap_start, 0);
    check("mid_rst_busy", busy, 0);
    check("mid_rst_cmd_ready", cmd_ready, 1);
    check("mid_rst_done_cnt", done_cnt, 0);
    check("mid_rst_lat_min", lat_min, ALL_ONES);
    ap_done = 1'b1;
    tick();
    ap_done = 1'b0;
    check("mid_late_done_err", err_done, 1);
    check("mid_late_done_cnt", done_cnt, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
